multiplier: RTL and testbench

- Sequential unsigned shift-and-add multiplier: 8-bit MP (multiplier) × 8-bit MC (multiplicand) → 16-bit product.
- Datapath block controlled externally.
  - It exposes the current multiplier LSB (b0) and a zero_flag completion indicator.
  - It accepts an add-select input (Psel) from a controller; Psel is normally tied to b0.
- Sits under a simple FSM or bench that issues load/enable.

---
 rtl/multiplier.sv | 119 +++++++++++
 tb/tb_multiplier.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/multiplier.sv
// rtl/multiplier.sv - sequential unsigned shift-and-add multiplier datapath
// Steps are gated externally by load/enable; Psel chooses whether each step adds.

module mult_shr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load_i)       q_d = d_i;
    else if (shift_i) q_d = q_q >> 1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_q <= '0;
    else      q_q <= q_d;
  end

  assign q_o = q_q;
endmodule

module mult_shl #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load_i)       q_d = d_i;
    else if (shift_i) q_d = q_q << 1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_q <= '0;
    else      q_q <= q_d;
  end

  assign q_o = q_q;
endmodule

module mult_acc #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         en_i,
  input  logic [W-1:0] addend_i,
  output logic [W-1:0] acc_o
);
  logic [W-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clear_i)   acc_d = '0;
    else if (en_i) acc_d = acc_q + addend_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) acc_q <= '0;
    else      acc_q <= acc_d;
  end

  assign acc_o = acc_q;
endmodule

module multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   MP,
  input  logic [WIDTH-1:0]   MC,
  input  logic               load,
  input  logic               enable,
  input  logic               Psel,
  output logic               zero_flag,
  output logic               b0,
  output logic [2*WIDTH-1:0] product
);
  logic [WIDTH-1:0]   mp_q;
  logic [2*WIDTH-1:0] mc_q;
  logic               step;

  // A step only happens while multiplier bits remain, so the product freezes once done.
  assign step = !load && enable && !zero_flag;

  mult_shr #(.W(WIDTH)) u_mp (
    .clk(clk), .rst(rst), .load_i(load), .shift_i(step), .d_i(MP), .q_o(mp_q)
  );

  mult_shl #(.W(2*WIDTH)) u_mc (
    .clk(clk), .rst(rst), .load_i(load), .shift_i(step),
    .d_i({{WIDTH{1'b0}}, MC}), .q_o(mc_q)
  );

  mult_acc #(.W(2*WIDTH)) u_acc (
    .clk(clk), .rst(rst), .clear_i(load), .en_i(step && Psel),
    .addend_i(mc_q), .acc_o(product)
  );

  assign zero_flag = (mp_q == '0);
  assign b0        = mp_q[0];
endmodule

// File: tb/tb_multiplier.sv
// tb/tb_multiplier.sv - self-checking bench for multiplier
// Arithmetic model compared every negedge plus directed literal checks.

module tb_multiplier;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  MP = '0, MC = '0;
  logic        load = 1'b0, enable = 1'b0;
  logic        psel_tie = 1'b1, psel_force = 1'b0;
  logic        psel;
  logic        zero_flag, b0;
  logic [15:0] product;

  int unsigned mp_m = 0, mc_m = 0, acc_m = 0;
  int          n_checks = 0, n_fail = 0;

  assign psel = psel_tie ? b0 : psel_force;

  multiplier #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .MP(MP), .MC(MC), .load(load), .enable(enable),
    .Psel(psel), .zero_flag(zero_flag), .b0(b0), .product(product)
  );

  always #5 clk = ~clk;

  // Reference: operands as plain integers, one multiply step = halve MP, double MC.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mp_m = 0; mc_m = 0; acc_m = 0;
    end else if (load) begin
      mp_m = MP; mc_m = MC; acc_m = 0;
    end else if (enable && mp_m != 0) begin
      if (psel_tie ? (mp_m % 2 == 1) : psel_force) acc_m = (acc_m + mc_m) % 65536;
      mc_m = (mc_m * 2) % 65536;
      mp_m = mp_m / 2;
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_product", int'(product), int'(acc_m));
    check("model_b0", int'(b0), int'(mp_m % 2));
    check("model_zero_flag", int'(zero_flag), (mp_m == 0) ? 1 : 0);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_load(input logic [7:0] mp, input logic [7:0] mc);
    load = 1'b1; enable = 1'b0; MP = mp; MC = mc;
    cyc(1);
    load = 1'b0; MP = 8'($urandom); MC = 8'($urandom);
  endtask

  initial begin
    MP = 8'($urandom); MC = 8'($urandom); load = 1'($urandom); enable = 1'($urandom);
    cyc(2);
    check("reset_product", int'(product), 0);
    check("reset_b0", int'(b0), 0);
    check("reset_zf", int'(zero_flag), 1);
    rst = 1'b1; load = 1'b0; enable = 1'b0;
    cyc(2);
    check("post_reset_product", int'(product), 0);
    check("post_reset_zf", int'(zero_flag), 1);

    do_load(8'd3, 8'd3);
    enable = 1'b1;
    cyc(1); check("3x3_step1", int'(product), 3);
    cyc(1); check("3x3_step2", int'(product), 9);
    check("3x3_zf", int'(zero_flag), 1);
    cyc(3); check("3x3_hold", int'(product), 9);

    do_load(8'd255, 8'd255);
    enable = 1'b1;
    cyc(7); check("255_zf_step7", int'(zero_flag), 0);
    cyc(1); check("255x255", int'(product), 65025);
    check("255_zf", int'(zero_flag), 1);

    do_load(8'd128, 8'd1);
    enable = 1'b1;
    cyc(7); check("128_noadd", int'(product), 0);
    cyc(1); check("128x1", int'(product), 128);

    do_load(8'd0, 8'd200);
    check("mp0_zf", int'(zero_flag), 1);
    enable = 1'b1;
    cyc(2); check("mp0_product", int'(product), 0);

    do_load(8'd13, 8'd0);
    enable = 1'b1;
    cyc(3); check("mc0_zf_step3", int'(zero_flag), 0);
    cyc(1); check("mc0_product", int'(product), 0);
    check("mc0_zf", int'(zero_flag), 1);

    do_load(8'd255, 8'd3);
    enable = 1'b1;
    cyc(2); enable = 1'b0;
    cyc(3);
    check("freeze_product", int'(product), 9);
    check("freeze_b0", int'(b0), 1);
    check("freeze_zf", int'(zero_flag), 0);
    load = 1'b1; enable = 1'b1; MP = 8'd5; MC = 8'd7;
    cyc(1); load = 1'b0;
    cyc(3); check("restart_5x7", int'(product), 35);
    check("restart_zf", int'(zero_flag), 1);

    psel_tie = 1'b0; psel_force = 1'b0;
    do_load(8'd6, 8'd9);
    enable = 1'b1;
    cyc(3);
    check("psel0_product", int'(product), 0);
    check("psel0_zf", int'(zero_flag), 1);
    psel_force = 1'b1;
    do_load(8'd2, 8'd5);
    enable = 1'b1;
    cyc(2); check("psel1_product", int'(product), 15);
    psel_tie = 1'b1;

    do_load(8'd15, 8'd15);
    enable = 1'b1;
    cyc(2); check("async_pre", int'(product), 45);
    #1 rst = 1'b0;
    #1;
    check("async_product", int'(product), 0);
    check("async_b0", int'(b0), 0);
    check("async_zf", int'(zero_flag), 1);
    cyc(1); rst = 1'b1;
    do_load(8'd15, 8'd15);
    enable = 1'b1;
    cyc(4); check("15x15", int'(product), 225);
    enable = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
